rf_read_sched: RTL and testbench
================================

// Module: rf_read_sched
// PURPOSE
//  Register-file read-port scheduler between allocate/rename (AR) and issue.
//  - Accepts one AR bundle of ISSUE_W instrs x NUM_SRCS sources.
//  - Merges duplicate PRF source addresses and time-multiplexes them over NUM_R_PORTS
//    registered (1-cycle latency) regfile read ports.
//  - Returns the bundle with all operand data through a valid/ready handshake.
// PARAMETERS
//  ISSUE_W      2   instrs per bundle
//  NUM_SRCS     2   sources per instr
//  NUM_R_PORTS  3   regfile read ports owned by this block
//  NUM_W_PORTS  2   regfile retire write ports snooped
//  SRC_LEN      5   register address width
//  DATA_LEN     32  data width
// PORTS
//  clk           in   1                        clock
//  rst           in   1                        reset, asynchronous, active-low
//  flush         in   1                        pipeline squash
//  in_valid      in   1                        AR bundle valid
//  in_ready      out  1                        bundle accepted when in_valid&in_ready
//  in_instr_val  in   ISSUE_W                  per-instr valid
//  in_src_addr   in   ISSUE_W*NUM_SRCS*SRC_LEN source register addresses
//  in_src_prf    in   ISSUE_W*NUM_SRCS         1: read regfile, 0: operand from ROB (ignored here)
//  rf_r_en       out  NUM_R_PORTS              read port enable
//  rf_r_addr     out  NUM_R_PORTS*SRC_LEN      read port address
//  rf_r_data     in   NUM_R_PORTS*DATA_LEN     read data, valid cycle after rf_r_en
//  wr_en         in   NUM_W_PORTS              retire write enable (already conflict-qualified)
//  wr_addr       in   NUM_W_PORTS*SRC_LEN      retire write address
//  wr_data       in   NUM_W_PORTS*DATA_LEN     retire write data
//  out_valid     out  1                        operand bundle valid
//  out_ready     in   1                        consumer accepts
//  out_src_data  out  ISSUE_W*NUM_SRCS*DATA_LEN operand data
//  out_src_vld   out  ISSUE_W*NUM_SRCS         1: operand supplied by this block
// BEHAVIOUR
//  - One clock (clk). Reset is asynchronous and active-low (rst=0).
//  - Reset values: state IDLE, out_valid=0, rf_r_en=0, rf_r_addr=0, out_src_data=0,
//    out_src_vld=0. in_ready=1 once rst=1.
//  - Source flat index f = i*NUM_SRCS+s.
//  - Need set: instr_val & src_prf & addr!=0. Addr 0 with instr_val&prf: data 0, vld=1, done
//    at capture. Others: vld=0, data 0.
//  - States: IDLE -> (accept) READ, or HOLD if no need-set member; READ -> DRAIN after
//    issuing the last batch; DRAIN -> HOLD; HOLD -> IDLE on out_ready; HOLD -> READ/HOLD on
//    out_ready with a simultaneous accept.
//  - in_ready = ~flush & (IDLE | (HOLD & out_ready)).
//  - READ batch: up to NUM_R_PORTS distinct addresses among pending (not done, not in-flight)
//    sources, lowest f first. Ports fill 0 upward; unused ports have en=0, addr=0.
//  - Every source sharing a granted address goes in-flight on that port. rf_r_data[p] is
//    captured into all of them on the next edge, marking them done.
//  - Batches are back-to-back: issue batch k while capturing batch k-1.
//  - Latency: accept at cycle t, B = ceil(U/NUM_R_PORTS) for U unique addresses. Batches
//    issue t+1..t+B; out_valid is high from t+B+2. If U=0, out_valid is high from t+1.
//  - out_src_data/out_src_vld hold stable while out_valid & ~out_ready.
//  - flush: any state -> IDLE next edge. In-flight rf_r_data is discarded, out_valid drops,
//    and no accept occurs in a flush cycle.
//  - Regfile write/read same edge returns the old value. Hazard handling is set by
//    RF_SCHED_WB_BYPASS_EN.
// CONFIGURATION
//  RF_SCHED_WB_BYPASS_EN defined:
//    - wr_en[w] matching a held source's address, in-flight or done, overwrites that data
//      with wr_data[w] until out handshake.
//    - Highest w wins. The bypass takes priority over the same-edge rf_r_data capture.
//    - Addresses are never deferred.
//  RF_SCHED_WB_BYPASS_EN undefined:
//    - A pending address matching any wr_en this cycle is not granted; it is granted a
//      later cycle.
//    - Done data is never updated. Latency may exceed the formula.
// TESTING
//  - Reset mid-READ (rst=0 for 1 cycle) -> out_valid=0, rf_r_en=0 immediately; in_ready=1
//    after release.
//  - Srcs {1,2},{3,4}, all prf, regfile r[n]=n -> ports 1,2,3 then 4; out_valid at t+4;
//    data {1,2,3,4}.
//  - Srcs {5,5},{5,0} -> one read of addr 5 on port 0 only; out at t+3; data {5,5,5,0};
//    vld=1111.
//  - prf=0 all -> out_valid at t+1, out_src_vld=0000, rf_r_en never asserted.
//  - Srcs {7,8}; wr_en addr 7 data 0xAA the cycle 7 is issued:
//    - macro on: data[0]=0xAA.
//    - macro off: addr 7 deferred a cycle, reads 0xAA from the regfile.
//  - out_ready=0 for 3 cycles -> data stable.
//  - flush during DRAIN -> IDLE; stale rf_r_data ignored; next bundle correct.

Source files
------------

// File: rtl/rf_read_sched.sv
// rf_read_sched: merges duplicate PRF sources of one AR bundle and time-multiplexes them over
// NUM_R_PORTS registered regfile read ports. Optional retire-write bypass: RF_SCHED_WB_BYPASS_EN.
module rf_read_sched #(
    parameter int ISSUE_W     = 2,
    parameter int NUM_SRCS    = 2,
    parameter int NUM_R_PORTS = 3,
    parameter int NUM_W_PORTS = 2,
    parameter int SRC_LEN     = 5,
    parameter int DATA_LEN    = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ISSUE_W-1:0]                    in_instr_val,
    input  logic [ISSUE_W*NUM_SRCS*SRC_LEN-1:0]   in_src_addr,
    input  logic [ISSUE_W*NUM_SRCS-1:0]           in_src_prf,
    output logic [NUM_R_PORTS-1:0]                rf_r_en,
    output logic [NUM_R_PORTS*SRC_LEN-1:0]        rf_r_addr,
    input  logic [NUM_R_PORTS*DATA_LEN-1:0]       rf_r_data,
    input  logic [NUM_W_PORTS-1:0]                wr_en,
    input  logic [NUM_W_PORTS*SRC_LEN-1:0]        wr_addr,
    input  logic [NUM_W_PORTS*DATA_LEN-1:0]       wr_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [ISSUE_W*NUM_SRCS*DATA_LEN-1:0]  out_src_data,
    output logic [ISSUE_W*NUM_SRCS-1:0]           out_src_vld
);
    localparam int NSRC = ISSUE_W * NUM_SRCS;
    localparam int PW   = (NUM_R_PORTS > 1) ? $clog2(NUM_R_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, HOLD} state_t;

    state_t              state_reg;
    logic                out_valid_reg;
    logic [NSRC-1:0]     pend_reg;
    logic [NSRC-1:0]     infl_reg;
    logic [NSRC-1:0]     vld_reg;
    logic [SRC_LEN-1:0]  addr_reg [NSRC];
    logic [DATA_LEN-1:0] data_reg [NSRC];
    logic [PW-1:0]       port_reg [NSRC];

    logic [SRC_LEN-1:0]  src_addr_in [NSRC];
    logic [NSRC-1:0]     need_in;
    logic [NSRC-1:0]     zero_in;
    logic [DATA_LEN-1:0] rd_data [NUM_R_PORTS];
    logic [SRC_LEN-1:0]  wr_addr_a [NUM_W_PORTS];

    logic [NUM_R_PORTS-1:0] port_en;
    logic [SRC_LEN-1:0]     port_addr [NUM_R_PORTS];
    logic [NSRC-1:0]        grant_src;
    logic [PW-1:0]          gport [NSRC];
    logic [NSRC-1:0]        blocked;
    logic                   accept;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign src_addr_in[gi] = in_src_addr[gi*SRC_LEN +: SRC_LEN];
            assign need_in[gi] = in_instr_val[gi/NUM_SRCS] & in_src_prf[gi] & (src_addr_in[gi] != '0);
            assign zero_in[gi] = in_instr_val[gi/NUM_SRCS] & in_src_prf[gi] & (src_addr_in[gi] == '0);
            assign out_src_data[gi*DATA_LEN +: DATA_LEN] = data_reg[gi];
        end
        for (gi = 0; gi < NUM_R_PORTS; gi++) begin : g_rport
            assign rd_data[gi] = rf_r_data[gi*DATA_LEN +: DATA_LEN];
            assign rf_r_addr[gi*SRC_LEN +: SRC_LEN] = port_addr[gi];
        end
        for (gi = 0; gi < NUM_W_PORTS; gi++) begin : g_wport
            assign wr_addr_a[gi] = wr_addr[gi*SRC_LEN +: SRC_LEN];
        end
    endgenerate

    assign in_ready    = ~flush & ((state_reg == IDLE) | ((state_reg == HOLD) & out_ready));
    assign accept      = in_valid & in_ready;
    assign rf_r_en     = port_en;
    assign out_valid   = out_valid_reg;
    assign out_src_vld = vld_reg;

    // Without the bypass, an address being written this cycle is held back so its read sees the new value.
    always_comb begin
        blocked = '0;
`ifndef RF_SCHED_WB_BYPASS_EN
        for (int f = 0; f < NSRC; f++) begin
            for (int w = 0; w < NUM_W_PORTS; w++) begin
                if (wr_en[w] && (wr_addr_a[w] == addr_reg[f])) begin
                    blocked[f] = 1'b1;
                end
            end
        end
`endif
    end

    // Batch selection: lowest source index first; duplicates join the port already holding the address.
    always_comb begin
        logic [PW:0] cnt;
        logic        joined;
        port_en   = '0;
        grant_src = '0;
        cnt       = '0;
        joined    = 1'b0;
        for (int p = 0; p < NUM_R_PORTS; p++) begin
            port_addr[p] = '0;
        end
        for (int f = 0; f < NSRC; f++) begin
            gport[f] = '0;
        end
        if (state_reg == READ) begin
            for (int f = 0; f < NSRC; f++) begin
                if (pend_reg[f] && !blocked[f]) begin
                    joined = 1'b0;
                    for (int p = 0; p < NUM_R_PORTS; p++) begin
                        if (!joined && port_en[p] && (port_addr[p] == addr_reg[f])) begin
                            joined       = 1'b1;
                            grant_src[f] = 1'b1;
                            gport[f]     = PW'(p);
                        end
                    end
                    if (!joined && (cnt < (PW+1)'(NUM_R_PORTS))) begin
                        port_en[cnt[PW-1:0]]   = 1'b1;
                        port_addr[cnt[PW-1:0]] = addr_reg[f];
                        grant_src[f]           = 1'b1;
                        gport[f]               = cnt[PW-1:0];
                        cnt                    = cnt + 1'b1;
                    end
                end
            end
        end
    end

`ifdef RF_SCHED_WB_BYPASS_EN
    logic [DATA_LEN-1:0] wr_data_a [NUM_W_PORTS];
    logic [NSRC-1:0]     byp_hit;
    logic [DATA_LEN-1:0] byp_data [NSRC];

    generate
        for (gi = 0; gi < NUM_W_PORTS; gi++) begin : g_wdata
            assign wr_data_a[gi] = wr_data[gi*DATA_LEN +: DATA_LEN];
        end
    endgenerate

    // A source is held once its read has been issued (this cycle or earlier); later w overrides earlier.
    always_comb begin
        for (int f = 0; f < NSRC; f++) begin
            byp_hit[f]  = 1'b0;
            byp_data[f] = '0;
            if ((state_reg != IDLE) && vld_reg[f] && (addr_reg[f] != '0) &&
                (!pend_reg[f] || grant_src[f])) begin
                for (int w = 0; w < NUM_W_PORTS; w++) begin
                    if (wr_en[w] && (wr_addr_a[w] == addr_reg[f])) begin
                        byp_hit[f]  = 1'b1;
                        byp_data[f] = wr_data_a[w];
                    end
                end
            end
        end
    end
`else
    logic wr_data_unused;
    assign wr_data_unused = ^wr_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            pend_reg      <= '0;
            infl_reg      <= '0;
            vld_reg       <= '0;
            for (int f = 0; f < NSRC; f++) begin
                addr_reg[f] <= '0;
                data_reg[f] <= '0;
                port_reg[f] <= '0;
            end
        end else if (flush) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            pend_reg      <= '0;
            infl_reg      <= '0;
        end else begin
            case (state_reg)
                READ: begin
                    for (int f = 0; f < NSRC; f++) begin
                        if (infl_reg[f]) begin
                            data_reg[f] <= rd_data[port_reg[f]];
                        end
                        port_reg[f] <= gport[f];
                    end
                    infl_reg <= grant_src;
                    pend_reg <= pend_reg & ~grant_src;
                    if ((pend_reg & ~grant_src) == '0) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    for (int f = 0; f < NSRC; f++) begin
                        if (infl_reg[f]) begin
                            data_reg[f] <= rd_data[port_reg[f]];
                        end
                    end
                    infl_reg      <= '0;
                    state_reg     <= HOLD;
                    out_valid_reg <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase

`ifdef RF_SCHED_WB_BYPASS_EN
            if (!((state_reg == HOLD) && out_ready)) begin
                for (int f = 0; f < NSRC; f++) begin
                    if (byp_hit[f]) begin
                        data_reg[f] <= byp_data[f];
                        // a read issued this cycle would return the pre-write value, so retire it now
                        if (grant_src[f]) begin
                            infl_reg[f] <= 1'b0;
                        end
                    end
                end
            end
`endif

            if (accept) begin
                state_reg     <= (|need_in) ? READ : HOLD;
                out_valid_reg <= ~(|need_in);
                pend_reg      <= need_in;
                infl_reg      <= '0;
                vld_reg       <= need_in | zero_in;
                for (int f = 0; f < NSRC; f++) begin
                    addr_reg[f] <= src_addr_in[f];
                    data_reg[f] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rf_read_sched.sv
// Directed bench for rf_read_sched with a registered-read regfile model (r[n]=n after reset).
module tb_rf_read_sched;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_instr_val = '0;
    logic [19:0]   in_src_addr = '0;
    logic [3:0]    in_src_prf = '0;
    logic [2:0]    rf_r_en;
    logic [14:0]   rf_r_addr;
    logic [95:0]   rf_r_data;
    logic [1:0]    wr_en = '0;
    logic [9:0]    wr_addr = '0;
    logic [63:0]   wr_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [127:0]  out_src_data;
    logic [3:0]    out_src_vld;

    int n_checks = 0;
    int n_fail = 0;

    rf_read_sched dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr_val(in_instr_val),
        .in_src_addr(in_src_addr), .in_src_prf(in_src_prf),
        .rf_r_en(rf_r_en), .rf_r_addr(rf_r_addr), .rf_r_data(rf_r_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_src_data(out_src_data), .out_src_vld(out_src_vld)
    );

    always #5 clk = ~clk;

    // Regfile: read registered, write lands on the same edge but the read still sees the old value.
    logic [31:0] mem [32];
    logic [31:0] rdata [3];
    assign rf_r_data = {rdata[2], rdata[1], rdata[0]};

    always @(posedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 32; n++) mem[n] <= 32'(n);
            for (int p = 0; p < 3; p++) rdata[p] <= 32'hDEAD0000 | 32'(p);
        end else begin
            for (int p = 0; p < 3; p++)
                rdata[p] <= rf_r_en[p] ? mem[rf_r_addr[p*5 +: 5]] : (32'hDEAD0000 | 32'(p));
            for (int w = 0; w < 2; w++)
                if (wr_en[w]) mem[wr_addr[w*5 +: 5]] <= wr_data[w*32 +: 32];
        end
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ival, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] a3, input logic [3:0] prf);
        in_valid     = 1'b1;
        in_instr_val = ival;
        in_src_addr  = {a3, a2, a1, a0};
        in_src_prf   = prf;
    endtask

    task automatic idle_in();
        in_valid     = 1'b0;
        in_instr_val = '0;
        in_src_addr  = '0;
        in_src_prf   = '0;
    endtask

    initial begin
        // reset
        tick();
        tick();
        check_val("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check_val("rst_rf_r_en", 128'(rf_r_en), 128'(3'b000));
        check_val("rst_rf_r_addr", 128'(rf_r_addr), 128'(15'd0));
        check_val("rst_out_data", out_src_data, 128'd0);
        check_val("rst_out_vld", 128'(out_src_vld), 128'(4'b0000));
        rst = 1'b1;
        #1;
        check_val("rst_in_ready", 128'(in_ready), 128'(1'b1));
        $display("tx reset done");

        // {1,2},{3,4}: two batches, then a 3-cycle stall
        tick();
        drive(2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 4'hF);
        #1;
        check_val("t1_in_ready", 128'(in_ready), 128'(1'b1));
        tick(); idle_in(); #1;
        check_val("t1_b0_en", 128'(rf_r_en), 128'(3'b111));
        check_val("t1_b0_addr", 128'(rf_r_addr), 128'({5'd3, 5'd2, 5'd1}));
        check_val("t1_busy_ready", 128'(in_ready), 128'(1'b0));
        tick(); #1;
        check_val("t1_b1_en", 128'(rf_r_en), 128'(3'b001));
        check_val("t1_b1_addr", 128'(rf_r_addr), 128'({5'd0, 5'd0, 5'd4}));
        check_val("t1_t2_valid", 128'(out_valid), 128'(1'b0));
        tick(); #1;
        check_val("t1_t3_valid", 128'(out_valid), 128'(1'b0));
        check_val("t1_t3_en", 128'(rf_r_en), 128'(3'b000));
        tick(); #1;
        check_val("t1_t4_valid", 128'(out_valid), 128'(1'b1));
        check_val("t1_data", out_src_data, {32'd4, 32'd3, 32'd2, 32'd1});
        check_val("t1_vld", 128'(out_src_vld), 128'(4'b1111));
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            check_val("stall_valid", 128'(out_valid), 128'(1'b1));
            check_val("stall_data", out_src_data, {32'd4, 32'd3, 32'd2, 32'd1});
        end
        out_ready = 1'b1;
        #1;
        check_val("hs_in_ready", 128'(in_ready), 128'(1'b1));
        tick(); #1;
        check_val("hs_valid_drop", 128'(out_valid), 128'(1'b0));
        $display("tx bundle {1,2},{3,4} done");

        // {5,5},{5,0}: one merged read
        drive(2'b11, 5'd5, 5'd5, 5'd5, 5'd0, 4'hF);
        tick(); idle_in(); #1;
        check_val("t2_en", 128'(rf_r_en), 128'(3'b001));
        check_val("t2_addr", 128'(rf_r_addr), 128'({5'd0, 5'd0, 5'd5}));
        tick(); #1;
        check_val("t2_t2_valid", 128'(out_valid), 128'(1'b0));
        tick();
        // all-ROB bundle presented while the previous one is handed off
        drive(2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 4'h0);
        #1;
        check_val("t2_t3_valid", 128'(out_valid), 128'(1'b1));
        check_val("t2_data", out_src_data, {32'd0, 32'd5, 32'd5, 32'd5});
        check_val("t2_vld", 128'(out_src_vld), 128'(4'b1111));
        check_val("t2_hold_ready", 128'(in_ready), 128'(1'b1));
        $display("tx bundle {5,5},{5,0} done");
        tick(); idle_in(); #1;
        check_val("t3_valid", 128'(out_valid), 128'(1'b1));
        check_val("t3_vld", 128'(out_src_vld), 128'(4'b0000));
        check_val("t3_data", out_src_data, 128'd0);
        check_val("t3_en", 128'(rf_r_en), 128'(3'b000));
        tick(); #1;
        check_val("t3_valid_drop", 128'(out_valid), 128'(1'b0));
        $display("tx bundle prf=0 done");

        // {7,8} with a retire write to 7 in the issue cycle
        drive(2'b01, 5'd7, 5'd8, 5'd0, 5'd0, 4'hF);
        tick(); idle_in();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'd0, 32'hAA};
        #1;
`ifdef RF_SCHED_WB_BYPASS_EN
        check_val("t4_en", 128'(rf_r_en), 128'(3'b011));
        check_val("t4_addr", 128'(rf_r_addr), 128'({5'd0, 5'd8, 5'd7}));
        tick(); wr_en = '0; #1;
        check_val("t4_t2_valid", 128'(out_valid), 128'(1'b0));
        tick(); #1;
`else
        check_val("t4_en", 128'(rf_r_en), 128'(3'b001));
        check_val("t4_addr", 128'(rf_r_addr), 128'({5'd0, 5'd0, 5'd8}));
        tick(); wr_en = '0; #1;
        check_val("t4_defer_en", 128'(rf_r_en), 128'(3'b001));
        check_val("t4_defer_addr", 128'(rf_r_addr), 128'({5'd0, 5'd0, 5'd7}));
        tick(); #1;
        check_val("t4_t3_valid", 128'(out_valid), 128'(1'b0));
        tick(); #1;
`endif
        check_val("t4_valid", 128'(out_valid), 128'(1'b1));
        check_val("t4_data", out_src_data, {32'd0, 32'd0, 32'd8, 32'hAA});
        check_val("t4_vld", 128'(out_src_vld), 128'(4'b0011));
        tick(); #1;
        $display("tx bundle {7,8} with write done");

        // reset in the middle of READ
        drive(2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 4'hF);
        tick(); idle_in(); #1;
        check_val("t5_read_en", 128'(rf_r_en), 128'(3'b111));
        rst = 1'b0;
        #1;
        check_val("t5_rst_valid", 128'(out_valid), 128'(1'b0));
        check_val("t5_rst_en", 128'(rf_r_en), 128'(3'b000));
        tick();
        rst = 1'b1;
        #1;
        check_val("t5_rel_ready", 128'(in_ready), 128'(1'b1));
        check_val("t5_rel_vld", 128'(out_src_vld), 128'(4'b0000));
        $display("tx reset mid-READ done");

        // flush during DRAIN, then a fresh bundle
        drive(2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 4'hF);
        tick(); idle_in();
        tick();
        tick();
        flush = 1'b1;
        drive(2'b11, 5'd9, 5'd10, 5'd9, 5'd11, 4'hF);
        #1;
        check_val("t6_flush_ready", 128'(in_ready), 128'(1'b0));
        tick(); flush = 1'b0; #1;
        check_val("t6_flushed_valid", 128'(out_valid), 128'(1'b0));
        check_val("t6_flushed_en", 128'(rf_r_en), 128'(3'b000));
        check_val("t6_idle_ready", 128'(in_ready), 128'(1'b1));
        tick(); idle_in(); #1;
        check_val("t6_en", 128'(rf_r_en), 128'(3'b111));
        check_val("t6_addr", 128'(rf_r_addr), 128'({5'd11, 5'd10, 5'd9}));
        tick(); #1;
        check_val("t6_t2_valid", 128'(out_valid), 128'(1'b0));
        tick(); #1;
        check_val("t6_valid", 128'(out_valid), 128'(1'b1));
        check_val("t6_data", out_src_data, {32'd11, 32'd9, 32'd10, 32'd9});
        check_val("t6_vld", 128'(out_src_vld), 128'(4'b1111));
        tick(); #1;
        $display("tx flush in DRAIN + bundle {9,10},{9,11} done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
